// File: rtl/n_bit_muldiv_unit.sv
// n_bit_muldiv_unit: iterative RV32M multiply/divide unit.
// A valid/ready request is accepted only in IDLE. Divide-by-zero and signed
// overflow are answered on the acceptance edge. Every other request runs N
// shift-add or restoring-subtract steps on operand magnitudes, then spends
// one FIX cycle restoring the sign and selecting the result. The result is
// held in DONE until the consumer takes it.
module n_bit_muldiv_unit #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [2:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] result_o,
  output logic         zero_flag_o
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Two's-complement negation, N bits.
  function automatic logic [N-1:0] neg_n(input logic [N-1:0] x);
    return ~x + {{(N-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation, 2N bits.
  function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] x);
    return ~x + {{(2*N-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [2*N-1:0]   acc_q, acc_d;        // product, or {remainder, quotient}
  logic [2*N-1:0]   mcand_q, mcand_d;    // shifted multiplicand, or divisor in low half
  logic [N-1:0]     mplier_q, mplier_d;  // multiplier, consumed LSB first
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sa_q, sa_d;          // operand A was negative (signed op)
  logic             sb_q, sb_d;          // operand B was negative (signed op)
  logic [N-1:0]     result_q, result_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Request decode, evaluated against the live inputs on the acceptance edge.
  logic             a_signed_s, b_signed_s;
  logic             sa_s, sb_s;
  logic [N-1:0]     mag_a_s, mag_b_s;
  logic             b_zero_s, overflow_s, special_s;
  logic [N-1:0]     spec_res_s;

  assign a_signed_s = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                      (op_i == OP_DIV)  || (op_i == OP_REM);
  assign b_signed_s = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign sa_s       = a_signed_s & a_i[N-1];
  assign sb_s       = b_signed_s & b_i[N-1];
  assign mag_a_s    = sa_s ? neg_n(a_i) : a_i;
  assign mag_b_s    = sb_s ? neg_n(b_i) : b_i;
  assign b_zero_s   = (b_i == {N{1'b0}});
  assign overflow_s = op_i[2] && !op_i[0] &&
                      (a_i == {1'b1, {(N-1){1'b0}}}) && (b_i == {N{1'b1}});
  assign special_s  = op_i[2] && (b_zero_s || overflow_s);

  // Result for divisions that bypass the iterative datapath (op_i[1] marks REM).
  always_comb begin
    spec_res_s = {N{1'b1}};
    if (b_zero_s) begin
      if (op_i[1]) begin
        spec_res_s = a_i;
      end else begin
        spec_res_s = {N{1'b1}};
      end
    end else begin
      if (op_i[1]) begin
        spec_res_s = {N{1'b0}};
      end else begin
        spec_res_s = a_i;
      end
    end
  end

  // Restoring-divide step: shift {rem, quot} left and trial-subtract the divisor.
  // The shifted remainder needs N+1 bits; the difference, when kept, fits in N.
  logic [N:0]       rem_sh_s;
  logic             ge_s;
  logic [N-1:0]     diff_s;

  assign rem_sh_s = acc_q[2*N-1:N-1];
  assign ge_s     = (rem_sh_s >= {1'b0, mcand_q[N-1:0]});
  assign diff_s   = rem_sh_s[N-1:0] - mcand_q[N-1:0];

  // Sign restoration and result selection used in the FIX cycle.
  logic [2*N-1:0]   prod_fix_s;
  logic [N-1:0]     quot_fix_s, rem_fix_s, fix_res_s;

  assign prod_fix_s = (sa_q ^ sb_q) ? neg_2n(acc_q) : acc_q;
  assign quot_fix_s = (sa_q ^ sb_q) ? neg_n(acc_q[N-1:0]) : acc_q[N-1:0];
  assign rem_fix_s  = sa_q ? neg_n(acc_q[2*N-1:N]) : acc_q[2*N-1:N];

  // Pick the architectural result for the latched operation.
  always_comb begin
    fix_res_s = prod_fix_s[N-1:0];
    case (op_q)
      OP_MUL:                       fix_res_s = prod_fix_s[N-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[2*N-1:N];
      OP_DIV, OP_DIVU:              fix_res_s = quot_fix_s;
      OP_REM, OP_REMU:              fix_res_s = rem_fix_s;
      default:                      fix_res_s = prod_fix_s[N-1:0];
    endcase
  end

  // Next-state and datapath control for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    result_d    = result_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          op_d       = op_i;
          sa_d       = sa_s;
          sb_d       = sb_s;
          cnt_d      = {CW{1'b0}};
          in_ready_d = 1'b0;
          if (op_i[2]) begin
            acc_d    = {{N{1'b0}}, mag_a_s};
            mcand_d  = {{N{1'b0}}, mag_b_s};
            mplier_d = {N{1'b0}};
          end else begin
            acc_d    = {(2*N){1'b0}};
            mcand_d  = {{N{1'b0}}, mag_a_s};
            mplier_d = mag_b_s;
          end
          if (special_s) begin
            result_d    = spec_res_s;
            zero_d      = ~|spec_res_s;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d     = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          acc_d = {(ge_s ? diff_s : rem_sh_s[N-1:0]), acc_q[N-2:0], ge_s};
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : {(2*N){1'b0}});
          mcand_d  = {mcand_q[2*N-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[N-1:1]};
        end
        if (cnt_q == CW'(N-1)) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        result_d    = fix_res_s;
        zero_d      = ~|fix_res_s;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d     = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= 3'b000;
      acc_q       <= {(2*N){1'b0}};
      mcand_q     <= {(2*N){1'b0}};
      mplier_q    <= {N{1'b0}};
      cnt_q       <= {CW{1'b0}};
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      result_q    <= {N{1'b0}};
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_flag_o = zero_q;

endmodule

// File: tb/tb_n_bit_muldiv_unit.sv
// Testbench for n_bit_muldiv_unit (N = 32): directed vectors with literal
// expectations, plus a per-cycle comparison against an arithmetic model.
module tb_n_bit_muldiv_unit;
  localparam int N  = 32;
  localparam int CW = 6;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'b000;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  result;
  logic          zero_flag;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  n_bit_muldiv_unit #(.N(N), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .zero_flag_o(zero_flag)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // RV32M semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0] ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      MUL:    begin p = ux * uy; return p[31:0];  end
      MULH:   begin p = sx * sy; return p[63:32]; end
      MULHSU: begin p = sx * uy; return p[63:32]; end
      MULHU:  begin p = ux * uy; return p[63:32]; end
      DIV:    begin if (y == 32'd0) return 32'hFFFFFFFF; p = sx / sy; return p[31:0]; end
      DIVU:   begin if (y == 32'd0) return 32'hFFFFFFFF; return x / y; end
      REM:    begin if (y == 32'd0) return x; p = sx % sy; return p[31:0]; end
      default: begin if (y == 32'd0) return x; return x % y; end
    endcase
  endfunction

  // Model state: outstanding request, cycle its result appears, last held result.
  bit          started = 1'b0;
  bit          pend = 1'b0;
  int          due = 0;
  logic [31:0] exp_new = 32'd0;
  logic [31:0] last_res = 32'd0;
  bit          vexp;
  logic [31:0] rexp;
  bit          spec;

  // Per-cycle comparison, then advance the model to what the next edge does.
  always @(negedge clk) begin
    cyc++;
    if (started) begin
      vexp = pend && (cyc >= due);
      rexp = vexp ? exp_new : last_res;
      chk("out_valid", 32'(out_valid), 32'(vexp));
      chk("in_ready", 32'(in_ready), 32'(!pend));
      chk("result", result, rexp);
      chk("zero_flag", 32'(zero_flag), 32'(rexp == 32'd0));
    end
    if (rst) begin
      started = 1'b1;
      pend = 1'b0;
      last_res = 32'd0;
    end else if (started) begin
      if (pend && (cyc >= due) && out_ready) begin
        pend = 1'b0;
        last_res = exp_new;
      end else if (!pend && in_valid) begin
        spec = op[2] && ((b == 32'd0) ||
               (!op[0] && (a == 32'h80000000) && (b == 32'hFFFFFFFF)));
        pend = 1'b1;
        exp_new = ref_op(op, a, b);
        due = cyc + (spec ? 1 : N + 2);
      end
    end
  end

  task automatic scramble();
    in_valid = 1'($urandom_range(1, 0));
    op = 3'($urandom_range(7, 0));
    a = $urandom;
    b = $urandom;
  endtask

  // Issue one request (called just after a rising edge, unit idle), check the
  // latency in cycles after the acceptance edge and the literal result, then
  // optionally hold off the consumer for 'hold' cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    out_ready = (hold == 0);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 100) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      lat++;
      scramble();
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result_lit", result, exp);
    chk("zero_lit", 32'(zero_flag), 32'(exp == 32'd0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      scramble();
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, exp);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (hold > 0) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("hs_valid_low", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero_flag), 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a DIVU.
    in_valid = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_zero", 32'(zero_flag), 32'd1);
    @(posedge clk); #1;
    run_op(DIVU, 32'd1000, 32'd3, 32'd333, 34, 0);

    // Multiplies.
    run_op(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
    run_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
    run_op(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
    run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0);
    run_op(MULH,   32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 34, 0);

    // Divides.
    run_op(DIV,  32'hFFFFFFF9, 32'd2,   32'hFFFFFFFD, 34, 0);
    run_op(REM,  32'hFFFFFFF9, 32'd2,   32'hFFFFFFFF, 34, 0);
    run_op(DIVU, 32'd100,      32'd7,   32'd14,       34, 0);
    run_op(REMU, 32'd100,      32'd7,   32'd2,        34, 0);
    run_op(DIVU, 32'hFFFFFFFF, 32'd1,   32'hFFFFFFFF, 34, 0);
    run_op(REM,  32'd17,       32'hFFFFFFFB, 32'd2,   34, 0);

    // Division special cases, answered one cycle after acceptance.
    run_op(DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
    run_op(REM,  32'd5,        32'd0,        32'd5,        1, 0);
    run_op(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op(REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);

    // Consumer backpressure.
    run_op(DIVU, 32'd1000, 32'd10, 32'd100, 34, 5);

    // Zero product still takes the full iteration count.
    run_op(MUL, 32'd0, 32'h12345678, 32'd0, 34, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
